signed_lane_unpacker: RTL and testbench

Output-side companion to the dual-mode signed adder. It accepts result words from the adder stage over a valid/ready handshake. A word is either one full-width signed result or two packed half-width lane results (8-bit mode). The block emits one signed lane value per beat on a narrower output stream, serialising packed words low lane first, and sits between the adder/accumulator array and the writeback path.

---
 rtl/signed_lane_unpacker.sv | 124 ++++++++++++
 tb/tb_signed_lane_unpacker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/signed_lane_unpacker.sv
// Serialises adder result words into one signed lane per output beat (packed words low lane first).
// Build option UNPACK_SAT_EN: clamp out-of-range full-mode words instead of truncating them.
module signed_lane_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 choose_8bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_lane,
  output logic                 out_last
);

  localparam int HALF = IN_WIDTH / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;
  logic                  mode_q, mode_d;
  logic                  accept;
  logic                  consume;
  logic [OUT_WIDTH-1:0]  lane0_ext;
  logic [OUT_WIDTH-1:0]  lane1_ext;
  logic [OUT_WIDTH-1:0]  full_red;

  // Packed lanes are always sign-extended, independent of the saturation option.
  generate
    if (OUT_WIDTH == HALF) begin : g_lane_same
      assign lane0_ext = word_q[HALF-1:0];
      assign lane1_ext = word_q[IN_WIDTH-1:HALF];
    end else begin : g_lane_ext
      assign lane0_ext = {{(OUT_WIDTH-HALF){word_q[HALF-1]}}, word_q[HALF-1:0]};
      assign lane1_ext = {{(OUT_WIDTH-HALF){word_q[IN_WIDTH-1]}}, word_q[IN_WIDTH-1:HALF]};
    end
  endgenerate

  generate
    if (OUT_WIDTH == IN_WIDTH) begin : g_full_pass
      assign full_red = word_q;
    end else begin : g_full_reduce
`ifdef UNPACK_SAT_EN
      // In range only if every bit from the output sign bit upward agrees.
      logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
      assign top_bits = word_q[IN_WIDTH-1:OUT_WIDTH-1];
      always_comb begin
        if ((&top_bits) || !(|top_bits)) begin
          full_red = word_q[OUT_WIDTH-1:0];
        end else if (word_q[IN_WIDTH-1]) begin
          full_red = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
          full_red = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
      end
`else
      assign full_red = word_q[OUT_WIDTH-1:0];
`endif
    end
  endgenerate

  always_comb begin
    out_valid = (state_q != EMPTY);
    out_lane  = (state_q == HI);
    out_last  = ((state_q == LO) && !mode_q) || (state_q == HI);
    in_ready  = (state_q == EMPTY) || (out_ready && out_last);
    accept    = in_valid && in_ready;
    consume   = out_valid && out_ready;

    out_data = '0;
    case (state_q)
      LO:      out_data = mode_q ? lane0_ext : full_red;
      HI:      out_data = lane1_ext;
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mode_d  = mode_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = LO;
      end
      LO: begin
        if (consume) begin
          if (mode_q) state_d = HI;
          else        state_d = accept ? LO : EMPTY;
        end
      end
      HI: begin
        if (consume) state_d = accept ? LO : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      word_d = in_data;
      mode_d = choose_8bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      word_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_signed_lane_unpacker.sv
// Directed bench for signed_lane_unpacker at default widths (32 in, 16 out).
module tb_signed_lane_unpacker;

  logic        clk;
  logic        reset;
  logic        choose_8bit;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_lane;
  logic        out_last;

  int checks_cnt = 0;
  int errors_cnt = 0;

  signed_lane_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .choose_8bit(choose_8bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs are changed and outputs checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    choose_8bit = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    check_val("rst_in_ready",  in_ready,  1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data",  out_data,  0);
    check_val("rst_out_lane",  out_lane,  0);
    check_val("rst_out_last",  out_last,  0);

    // Packed word: lane 0 = 3, lane 1 = -2
    in_valid = 1'b1; choose_8bit = 1'b1; in_data = 32'hFFFE0003;
    cyc();
    in_valid = 1'b0;
    settle();
    check_val("pk_b1_valid", out_valid, 1);
    check_val("pk_b1_data",  out_data,  16'h0003);
    check_val("pk_b1_lane",  out_lane,  0);
    check_val("pk_b1_last",  out_last,  0);
    check_val("pk_b1_ready", in_ready,  0);
    cyc();
    settle();
    check_val("pk_b2_data",  out_data,  16'hFFFE);
    check_val("pk_b2_lane",  out_lane,  1);
    check_val("pk_b2_last",  out_last,  1);
    check_val("pk_b2_ready", in_ready,  1);
    cyc();
    settle();
    check_val("pk_idle_valid", out_valid, 0);

    // Full word out of the 16-bit range
    in_valid = 1'b1; choose_8bit = 1'b0; in_data = 32'h00012345;
    cyc();
    in_valid = 1'b0;
    settle();
`ifdef UNPACK_SAT_EN
    check_val("full_ovf_data", out_data, 16'h7FFF);
`else
    check_val("full_ovf_data", out_data, 16'h2345);
`endif
    check_val("full_ovf_lane", out_lane, 0);
    check_val("full_ovf_last", out_last, 1);
    cyc();

    // Back-to-back full words, no bubble
    in_valid = 1'b1; choose_8bit = 1'b0; in_data = 32'hFFFF8000;
    cyc();
    in_data = 32'hFFFF0000;
    settle();
    check_val("b2b_w1_data",  out_data, 16'h8000);
    check_val("b2b_w1_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    settle();
    check_val("b2b_w2_valid", out_valid, 1);
`ifdef UNPACK_SAT_EN
    check_val("b2b_w2_data", out_data, 16'h8000);
`else
    check_val("b2b_w2_data", out_data, 16'h0000);
`endif
    cyc();
    settle();
    check_val("b2b_idle_valid", out_valid, 0);

    // Backpressure in the middle of a packed word, next word waiting
    in_valid = 1'b1; choose_8bit = 1'b1; in_data = 32'h12348765;
    cyc();
    out_ready = 1'b0; choose_8bit = 1'b0; in_data = 32'h00000055;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val($sformatf("bp%0d_valid", i), out_valid, 1);
      check_val($sformatf("bp%0d_data", i),  out_data,  16'h8765);
      check_val($sformatf("bp%0d_lane", i),  out_lane,  0);
      check_val($sformatf("bp%0d_last", i),  out_last,  0);
      check_val($sformatf("bp%0d_ready", i), in_ready,  0);
      cyc();
    end
    out_ready = 1'b1;
    settle();
    check_val("bp_lo_release_ready", in_ready, 0);
    cyc();
    settle();
    check_val("bp_hi_data",  out_data, 16'h1234);
    check_val("bp_hi_lane",  out_lane, 1);
    check_val("bp_hi_last",  out_last, 1);
    check_val("bp_hi_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    settle();
    check_val("bp_next_valid", out_valid, 1);
    check_val("bp_next_data",  out_data,  16'h0055);
    check_val("bp_next_lane",  out_lane,  0);
    check_val("bp_next_last",  out_last,  1);
    cyc();

    // Reset while presenting lane 1
    in_valid = 1'b1; choose_8bit = 1'b1; in_data = 32'hAAAA5555;
    cyc();
    in_valid = 1'b0;
    cyc();
    settle();
    check_val("rh_hi_lane", out_lane, 1);
    reset = 1'b1;
    cyc();
    settle();
    check_val("rh_out_valid", out_valid, 0);
    check_val("rh_in_ready",  in_ready,  1);
    check_val("rh_out_data",  out_data,  0);
    reset = 1'b0;
    in_valid = 1'b1; choose_8bit = 1'b0; in_data = 32'h00000042;
    cyc();
    in_valid = 1'b0;
    settle();
    check_val("rh_new_data", out_data, 16'h0042);
    check_val("rh_new_lane", out_lane, 0);
    check_val("rh_new_last", out_last, 1);
    cyc();
    settle();
    check_val("rh_no_leftover", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
